// File: rtl/symbol_train_rx.sv
// Preamble receiver: drops the short-training and guard samples, buffers the first
// long training symbol and streams out the average of both long training symbols.
module symbol_train_rx #(
  parameter int STS_LEN = 160,
  parameter int GI_LEN  = 32,
  parameter int LTS_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] train_din,
  input  logic        train_din_vld,
  input  logic        train_din_last,
  input  logic [8:0]  train_din_Index,
  output logic        train_din_rdy,
  output logic [15:0] lts_dout,
  output logic        lts_dout_vld,
  output logic        lts_dout_last,
  output logic [5:0]  lts_dout_Index,
  input  logic        lts_dout_rdy,
  output logic        frame_done,
  output logic        err
);

  localparam int LTS1_START = STS_LEN + GI_LEN;
  localparam int LTS2_START = LTS1_START + LTS_LEN;
  localparam int LAST_CNT   = LTS2_START + LTS_LEN - 1;

  typedef enum logic [2:0] {IDLE, STS, GI, LTS1, LTS2} state_t;

  state_t      state;
  logic [8:0]  cnt;
  logic [15:0] buf_mem [LTS_LEN];

  logic        acc_p0;
  logic        idx_err_p0;
  logic        at_end_p0;
  logic        early_last_p0;
  logic        miss_last_p0;
  logic [5:0]  lts1_addr_p0;
  logic [5:0]  lts2_addr_p0;
  logic [15:0] lts1_smp_p0;

  // Floor average of two signed 8-bit components, computed at 9 bits.
  function automatic logic [7:0] avg8(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    return 8'(s >>> 1);
  endfunction

  // Only the LTS2 phase can stall upstream, and only while an output is pending.
  assign train_din_rdy = (state != LTS2) | ~lts_dout_vld | lts_dout_rdy;

  assign acc_p0        = train_din_vld & train_din_rdy;
  assign idx_err_p0    = acc_p0 & (train_din_Index != cnt);
  assign at_end_p0     = (cnt == 9'(LAST_CNT));
  assign early_last_p0 = acc_p0 & train_din_last & ~at_end_p0;
  assign miss_last_p0  = acc_p0 & ~train_din_last & at_end_p0;
  assign lts1_addr_p0  = 6'(cnt - 9'(LTS1_START));
  assign lts2_addr_p0  = 6'(cnt - 9'(LTS2_START));
  assign lts1_smp_p0   = buf_mem[lts2_addr_p0];

  always_ff @(posedge clk) begin
    if (acc_p0 && state == LTS1)
      buf_mem[lts1_addr_p0] <= train_din;
  end

  // p0 -> p1: accepted sample updates control state and the registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      lts_dout       <= '0;
      lts_dout_vld   <= 1'b0;
      lts_dout_last  <= 1'b0;
      lts_dout_Index <= '0;
      frame_done     <= 1'b0;
      err            <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (lts_dout_rdy)
        lts_dout_vld <= 1'b0;
      if (acc_p0) begin
        err <= ((state == IDLE) ? 1'b0 : err) | idx_err_p0 | early_last_p0 | miss_last_p0;
        if (early_last_p0) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= at_end_p0 ? '0 : cnt + 9'd1;
          case (state)
            IDLE: state <= STS;
            STS:  if (cnt == 9'(LTS1_START - GI_LEN - 1)) state <= GI;
            GI:   if (cnt == 9'(LTS1_START - 1)) state <= LTS1;
            LTS1: if (cnt == 9'(LTS2_START - 1)) state <= LTS2;
            LTS2: if (at_end_p0) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
            default: state <= IDLE;
          endcase
          if (state == LTS2) begin
            lts_dout       <= {avg8(lts1_smp_p0[15:8], train_din[15:8]),
                               avg8(lts1_smp_p0[7:0], train_din[7:0])};
            lts_dout_vld   <= 1'b1;
            lts_dout_Index <= lts2_addr_p0;
            lts_dout_last  <= (lts2_addr_p0 == 6'(LTS_LEN - 1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_symbol_train_rx.sv
// Directed bench for symbol_train_rx: full preamble frames with error, stall and reset cases.
module tb_symbol_train_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] train_din = '0;
  logic        train_din_vld = 1'b0;
  logic        train_din_last = 1'b0;
  logic [8:0]  train_din_Index = '0;
  logic        train_din_rdy;
  logic [15:0] lts_dout;
  logic        lts_dout_vld;
  logic        lts_dout_last;
  logic [5:0]  lts_dout_Index;
  logic        lts_dout_rdy = 1'b1;
  logic        frame_done;
  logic        err;

  symbol_train_rx dut (
    .clk(clk), .rst_n(rst_n),
    .train_din(train_din), .train_din_vld(train_din_vld), .train_din_last(train_din_last),
    .train_din_Index(train_din_Index), .train_din_rdy(train_din_rdy),
    .lts_dout(lts_dout), .lts_dout_vld(lts_dout_vld), .lts_dout_last(lts_dout_last),
    .lts_dout_Index(lts_dout_Index), .lts_dout_rdy(lts_dout_rdy),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [15:0] lts1 [64];
  logic [15:0] lts2 [64];
  int cur_cnt;
  bit tog, accepted, pend_fd, prev_stall;
  int fd_n, fd_bad, rdy_bad, hold_bad, timeouts;
  logic [15:0] prev_d;
  logic [5:0]  prev_i;
  logic        prev_l;
  logic [15:0] cap_d[$];
  logic [5:0]  cap_i[$];
  logic        cap_l[$];

  function automatic int half_floor(input int s);
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int si, sq;
    si = half_floor(int'($signed(a[15:8])) + int'($signed(b[15:8])));
    sq = half_floor(int'($signed(a[7:0])) + int'($signed(b[7:0])));
    return {8'(si), 8'(sq)};
  endfunction

  // One cycle, entered at a falling edge with inputs already driven.
  task automatic tick();
    logic exp_rdy;
    if (tog) lts_dout_rdy = ~lts_dout_rdy;
    #1;
    accepted = train_din_vld && train_din_rdy;
    exp_rdy = (train_din_vld && cur_cnt >= 256) ? (!lts_dout_vld || lts_dout_rdy) : 1'b1;
    if (train_din_rdy !== exp_rdy) rdy_bad++;
    if (frame_done !== pend_fd) fd_bad++;
    if (frame_done === 1'b1) fd_n++;
    pend_fd = accepted && cur_cnt == 319;
    if (prev_stall && (lts_dout_vld !== 1'b1 || lts_dout !== prev_d ||
                       lts_dout_Index !== prev_i || lts_dout_last !== prev_l)) hold_bad++;
    prev_stall = lts_dout_vld && !lts_dout_rdy;
    prev_d = lts_dout; prev_i = lts_dout_Index; prev_l = lts_dout_last;
    if (lts_dout_vld && lts_dout_rdy) begin
      cap_d.push_back(lts_dout); cap_i.push_back(lts_dout_Index); cap_l.push_back(lts_dout_last);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int idx_err_at, input int last_at, input bit toggle,
                           input int abort_at, input bit drop_last);
    fd_n = 0; fd_bad = 0; rdy_bad = 0; hold_bad = 0; timeouts = 0;
    pend_fd = 0; prev_stall = 0;
    cap_d.delete(); cap_i.delete(); cap_l.delete();
    for (int c = 0; c < 320; c++) begin
      if (c == abort_at) return;
      cur_cnt = c;
      train_din = (c >= 256) ? lts2[c-256] : (c >= 192) ? lts1[c-192] : 16'(c * 7);
      train_din_Index = 9'((c == idx_err_at) ? c + 1 : c);
      train_din_last = ((c == 319) && !drop_last) || (c == last_at);
      train_din_vld = 1'b1;
      tog = toggle && c >= 256;
      accepted = 0;
      for (int g = 0; g < 8 && !accepted; g++) tick();
      if (!accepted) begin timeouts++; break; end
      if (train_din_last) break;
    end
    train_din_vld = 1'b0; train_din_last = 1'b0; tog = 0; lts_dout_rdy = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (lts_dout !== 16'h0) $display("FAIL reset_dout: got %h want 0000", lts_dout); else passed++;
    checks++; if (lts_dout_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", lts_dout_vld); else passed++;
    checks++; if (lts_dout_last !== 1'b0) $display("FAIL reset_last: got %b want 0", lts_dout_last); else passed++;
    checks++; if (lts_dout_Index !== 6'd0) $display("FAIL reset_index: got %0d want 0", lts_dout_Index); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    checks++; if (train_din_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", train_din_rdy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 64; i++) begin
      lts1[i] = 16'(i * 16'h0b3d + 16'h1234);
      lts2[i] = lts1[i];
    end
    run_frame(-1, -1, 0, -1, 0);
    checks++; if (cap_d.size() !== 64) $display("FAIL nominal_count: got %0d want 64", cap_d.size()); else passed++;
    for (int i = 0; i < 64 && i < cap_d.size(); i++) begin
      checks++;
      if ({cap_d[i], cap_i[i], cap_l[i]} !== {lts1[i], 6'(i), i == 63})
        $display("FAIL nominal_out[%0d]: got %h/%0d/%b want %h/%0d/%b", i, cap_d[i], cap_i[i], cap_l[i], lts1[i], i, i == 63);
      else passed++;
    end
    checks++; if (fd_n !== 1 || fd_bad !== 0) $display("FAIL nominal_done: got pulses %0d bad %0d want 1/0", fd_n, fd_bad); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL nominal_err: got %b want 0", err); else passed++;
    checks++; if (rdy_bad !== 0 || timeouts !== 0) $display("FAIL nominal_rdy: got %0d/%0d want 0/0", rdy_bad, timeouts); else passed++;
  endtask

  task automatic test_average();
    logic [15:0] e;
    for (int i = 0; i < 64; i++) begin
      lts1[i] = 16'($urandom); lts2[i] = 16'($urandom);
    end
    lts1[0] = 16'h10F0; lts2[0] = 16'h1181;
    lts1[1] = 16'h8080; lts2[1] = 16'h8080;
    lts1[2] = 16'h7F7F; lts2[2] = 16'h7F01;
    run_frame(-1, -1, 0, -1, 0);
    checks++; if (cap_d.size() !== 64) $display("FAIL avg_count: got %0d want 64", cap_d.size()); else passed++;
    if (cap_d.size() >= 3) begin
      checks++; if (cap_d[0] !== 16'h10B8) $display("FAIL avg_10f0_1181: got %h want 10b8", cap_d[0]); else passed++;
      checks++; if (cap_d[1] !== 16'h8080) $display("FAIL avg_min: got %h want 8080", cap_d[1]); else passed++;
      checks++; if (cap_d[2] !== 16'h7F40) $display("FAIL avg_max: got %h want 7f40", cap_d[2]); else passed++;
    end
    for (int i = 0; i < 64 && i < cap_d.size(); i++) begin
      e = model(lts1[i], lts2[i]);
      checks++;
      if ({cap_d[i], cap_i[i], cap_l[i]} !== {e, 6'(i), i == 63})
        $display("FAIL avg_out[%0d]: got %h/%0d/%b want %h/%0d/%b", i, cap_d[i], cap_i[i], cap_l[i], e, i, i == 63);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    for (int i = 0; i < 64; i++) begin
      lts1[i] = 16'($urandom); lts2[i] = 16'($urandom);
    end
    run_frame(-1, -1, 1, -1, 0);
    checks++; if (cap_d.size() !== 64) $display("FAIL bp_count: got %0d want 64", cap_d.size()); else passed++;
    for (int i = 0; i < 64 && i < cap_d.size(); i++) begin
      e = model(lts1[i], lts2[i]);
      checks++;
      if ({cap_d[i], cap_i[i], cap_l[i]} !== {e, 6'(i), i == 63})
        $display("FAIL bp_out[%0d]: got %h/%0d/%b want %h/%0d/%b", i, cap_d[i], cap_i[i], cap_l[i], e, i, i == 63);
      else passed++;
    end
    checks++; if (hold_bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); else passed++;
    checks++; if (rdy_bad !== 0) $display("FAIL bp_rdy: got %0d wrong cycles want 0", rdy_bad); else passed++;
    checks++; if (fd_n !== 1 || fd_bad !== 0) $display("FAIL bp_done: got pulses %0d bad %0d want 1/0", fd_n, fd_bad); else passed++;
  endtask

  task automatic test_index_err();
    run_frame(4, -1, 0, -1, 0);
    checks++; if (err !== 1'b1) $display("FAIL idx_err: got %b want 1", err); else passed++;
    checks++; if (cap_d.size() !== 64) $display("FAIL idx_count: got %0d want 64", cap_d.size()); else passed++;
    checks++; if (fd_n !== 1 || fd_bad !== 0) $display("FAIL idx_done: got pulses %0d bad %0d want 1/0", fd_n, fd_bad); else passed++;
  endtask

  task automatic test_early_last();
    run_frame(-1, 200, 0, -1, 0);
    checks++; if (err !== 1'b1) $display("FAIL early_err: got %b want 1", err); else passed++;
    checks++; if (cap_d.size() !== 0) $display("FAIL early_count: got %0d want 0", cap_d.size()); else passed++;
    checks++; if (fd_n !== 0 || fd_bad !== 0) $display("FAIL early_done: got pulses %0d bad %0d want 0/0", fd_n, fd_bad); else passed++;
  endtask

  task automatic test_missing_last();
    run_frame(-1, -1, 0, -1, 1);
    checks++; if (err !== 1'b1) $display("FAIL miss_err: got %b want 1", err); else passed++;
    checks++; if (cap_d.size() !== 64) $display("FAIL miss_count: got %0d want 64", cap_d.size()); else passed++;
    checks++; if (fd_n !== 1 || fd_bad !== 0) $display("FAIL miss_done: got pulses %0d bad %0d want 1/0", fd_n, fd_bad); else passed++;
  endtask

  task automatic test_reset_mid();
    run_frame(4, -1, 0, 270, 0);
    train_din_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (lts_dout !== 16'h0) $display("FAIL mid_dout: got %h want 0000", lts_dout); else passed++;
    checks++; if (lts_dout_vld !== 1'b0) $display("FAIL mid_vld: got %b want 0", lts_dout_vld); else passed++;
    checks++; if (lts_dout_Index !== 6'd0 || lts_dout_last !== 1'b0)
      $display("FAIL mid_index: got %0d/%b want 0/0", lts_dout_Index, lts_dout_last); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL mid_err: got %b want 0", err); else passed++;
    checks++; if (train_din_rdy !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL mid_rdy_done: got %b/%b want 1/0", train_din_rdy, frame_done); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_nominal();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_average();
    test_back_to_back();
    test_index_err();
    test_nominal();
    test_early_last();
    test_nominal();
    test_missing_last();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/symbol_train_rx.md
SYMBOL_TRAIN_RX -- requirements
Module: symbol_train_rx

Interface
REQ-001 Parameters, one per line:
- STS_LEN, 160, short-training sample count.
- GI_LEN, 32, long-training guard-interval sample count.
- LTS_LEN, 64, samples per long training symbol.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 train_din  input  16  sample {I[15:8], Q[7:0]}, each component two's complement.
REQ-005 train_din_vld  input  1  sample valid (AXI-Stream TVALID).
REQ-006 train_din_last  input  1  last preamble sample (TLAST).
REQ-007 train_din_Index  input  9  transmitter sample index, 0-319 (TUSER).
REQ-008 train_din_rdy  output  1  sink ready (TREADY).
REQ-009 lts_dout  output  16  averaged long-training sample {I[15:8], Q[7:0]}.
REQ-010 lts_dout_vld  output  1  output valid.
REQ-011 lts_dout_last  output  1  asserted with the 64th averaged sample.
REQ-012 lts_dout_Index  output  6  averaged sample position, 0-63.
REQ-013 lts_dout_rdy  input  1  downstream ready.
REQ-014 frame_done  output  1  one-cycle pulse when sample 319 is accepted.
REQ-015 err  output  1  sticky framing error flag.

Function
REQ-016 An input sample is accepted only when train_din_vld and train_din_rdy are both 1 in the same cycle.
REQ-017 An internal 9-bit counter cnt SHALL count accepted samples.
- cnt is 0 at frame start and increments by 1 per accepted sample.
- Phases by cnt: STS 0-159, GI 160-191, LTS1 192-255, LTS2 256-319.
REQ-018 FSM states IDLE, STS, GI, LTS1, LTS2 SHALL apply. Transitions occur on acceptance of these samples:
- IDLE->STS on the first sample.
- STS->GI at cnt 159.
- GI->LTS1 at cnt 191.
- LTS1->LTS2 at cnt 255.
- LTS2->IDLE at cnt 319.
REQ-019 In IDLE, STS, GI and LTS1, train_din_rdy SHALL be 1.
REQ-020 In LTS2, train_din_rdy SHALL equal (!lts_dout_vld | lts_dout_rdy).
REQ-021 STS and GI samples SHALL be discarded. This includes the windowed overlap sample at cnt 160.
REQ-022 Each LTS1 sample SHALL be written to a 64x16 buffer at address cnt-192.
REQ-023 For each LTS2 sample b, the block SHALL read buffer entry a at address cnt-256 and output the averaged sample.
- Each component is (a+b) computed at 9 bits, then arithmetically shifted right by 1 (floor), then truncated to 8 bits.
REQ-024 The averaged sample SHALL appear on lts_dout the cycle after the LTS2 sample is accepted (latency 1).
- lts_dout_Index = cnt-256.
- lts_dout_last = 1 when that index is 63.
REQ-025 lts_dout, lts_dout_Index and lts_dout_last SHALL hold stable while lts_dout_vld=1 and lts_dout_rdy=0.
REQ-026 lts_dout_vld SHALL clear after a cycle with lts_dout_rdy=1 and no new LTS2 acceptance in that same cycle.
REQ-027 Index mismatch: if train_din_Index != cnt on any accepted sample, err SHALL be set, and processing SHALL continue using cnt.
REQ-028 Early last: if train_din_last=1 on an accepted sample with cnt<319, the block SHALL:
- set err;
- return to IDLE with cnt=0;
- produce no further outputs for that frame;
- not pulse frame_done.
REQ-029 Missing last: if the sample at cnt 319 is accepted with train_din_last=0, err SHALL be set and the frame SHALL complete normally.
REQ-030 frame_done SHALL pulse 1 for one cycle in the cycle after sample 319 is accepted.
REQ-031 err SHALL clear only on reset or on acceptance of the first sample of a new frame (IDLE->STS), unless that same sample itself causes an error.
REQ-032 Buffer contents need no reset. Every entry SHALL be rewritten in LTS1 before it is read.

Reset
REQ-033 While rst_n=0, the block SHALL hold:
- state=IDLE and cnt=0;
- lts_dout=0, lts_dout_vld=0, lts_dout_last=0, lts_dout_Index=0;
- frame_done=0 and err=0;
- train_din_rdy=1.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately. The first sample accepted after release starts a new frame at cnt 0.

Verification
REQ-035 Nominal frame: 320 back-to-back samples, Index 0-319, last on 319, LTS1 and LTS2 equal, lts_dout_rdy=1.
- Expect 64 outputs equal to LTS1, Index 0-63, last on index 63.
- Expect frame_done one cycle after sample 319 and err=0.
REQ-036 Averaging: LTS1 sample 0x10F0, LTS2 sample 0x1181 -> output 0x10B8.
- I: (16+17)>>1 = 16.
- Q: (-16+-127)>>1 = -72.
REQ-037 Backpressure: toggle lts_dout_rdy 0/1 every cycle during LTS2.
- train_din_rdy follows REQ-020.
- Output holds stable while stalled.
- No sample is lost or duplicated; 64 outputs are produced.
REQ-038 Error cases:
- Index 5 driven at cnt 4 -> err=1 and the frame still completes.
- last at cnt 200 -> err=1, back to IDLE, no outputs, no frame_done.
REQ-039 Reset mid-frame: assert rst_n=0 at cnt 270 -> all outputs at their reset values. A full 320-sample frame after release produces the correct 64 outputs.
